demux_1to4_reg: RTL and testbench
=================================

Name: demux_1to4_reg

Overview:
- Registered 1-to-4 demultiplexer that steers one 16-bit input word to one of four output channels (a, b, c, d) selected by a 2-bit op code.
- It is the distribution end of the 4-to-1 selection path.
- Each output channel has a one-entry holding register with valid/ready handshake, so a stalled channel does not block words bound for the other channels.
- Sits between a single producer and four independent 16-bit consumers.

Parameters:
- WIDTH, 16, data width of input word and each output channel.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to distribute.
- in_op  input  2  destination select: 00=a, 01=b, 10=c, 11=d.
- in_valid  input  1  producer has a word on in_data/in_op.
- in_ready  output  1  block accepts the word this cycle.
- out_a, out_b, out_c, out_d  output  WIDTH  channel holding-register contents.
- valid_a, valid_b, valid_c, valid_d  output  1  channel register holds an undelivered word.
- ready_a, ready_b, ready_c, ready_d  input  1  consumer takes the word this cycle.
- xfer_cnt  output  CNT_W  count of input words accepted since reset.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All valid_x = 0, all out_x = 0, xfer_cnt = 0.
  - rst overrides every other input that cycle, and any word held mid-handshake is discarded.
- Per-channel state is two states, EMPTY (valid_x=0) and FULL (valid_x=1).
- Output handshake:
  - An output transfer occurs when valid_x & ready_x at the clk edge.
  - FULL→EMPTY when the channel drains with no new write.
- Channel acceptance:
  - Channel x can accept when it is EMPTY, or when it is FULL and draining this cycle (valid_x & ready_x).
  - in_ready is combinational: it is high when the channel addressed by in_op can accept.
  - in_ready does not depend on the other channels.
  - in_ready may be high while in_valid=0.
- Input handshake:
  - An input transfer occurs when in_valid & in_ready at the clk edge.
  - The addressed register loads in_data, and its valid_x is set to 1 next cycle.
  - EMPTY→FULL on write. FULL→FULL on simultaneous drain+write: the old word is delivered and the new word is loaded, so there is no bubble.
- Latency: a word accepted at edge N appears on out_x with valid_x=1 after edge N; one-cycle latency.
- Stability: while valid_x=1 and ready_x=0, out_x and valid_x hold unchanged regardless of input activity.
- Non-addressed channels are unaffected by input activity. Their registers and valids change only through their own drain.
- in_op may change every cycle. A back-to-back stream to different channels sustains one word per cycle.
- out_x is not cleared on drain; it retains the last word with valid_x=0.
- Counter:
  - xfer_cnt increments by 1 per input transfer.
  - It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- No word is ever dropped or duplicated outside reset.

Optional Feature:
- Macro DEMUX_BROADCAST_EN.
- When defined:
  - An extra input port in_bcast (1 bit) is present.
  - With in_bcast=1, in_op is ignored, and in_ready = AND over all four channels' accept condition.
  - On transfer, in_data loads into all four registers, all four valids are set, and xfer_cnt increments by 1.
  - With in_bcast=0, behaviour is as above.
- When not defined: the port is absent, and the logic is unicast only.

Test Plan:
1. Reset then unicast:
   - Stimulus: rst=1 for 2 cycles, then in_op=00, in_data=16'h0007, in_valid=1 for one cycle, all ready_x=1.
   - Required response: in_ready=1; the next cycle shows out_a=16'h0007, valid_a=1; the cycle after that valid_a=0; xfer_cnt=1.
2. Backpressure isolation:
   - Stimulus: ready_b=0; send 16'hFFFD to b, then 16'hF16D to b.
   - Required response: second word sees in_ready=0 and is held; out_b stays 16'hFFFD.
   - Also: sending 16'd56 to c during the stall is accepted next cycle, and out_c=16'd56.
3. Full-throughput drain+write:
   - Stimulus: channel d FULL with 16'hF0FD, ready_d=1, in_op=11, in_data=16'd45 in the same cycle.
   - Required response: in_ready=1; out_d=16'd45, valid_d=1 next cycle; xfer_cnt increments once.
4. Round-robin stream:
   - Stimulus: in_op cycles 00,01,10,11 with data 8,4,45,16'hF0FD on consecutive cycles, all ready=1.
   - Required response: in_ready=1 every cycle; each channel shows its word for exactly one cycle.
5. Reset mid-operation and counter wrap:
   - Stimulus: rst=1 while valid_a=1, ready_a=0.
   - Required response: valid_a=0, out_a=0, xfer_cnt=0 next cycle.
   - Stimulus: CNT_W=4 build, 17 accepted words.
   - Required response: xfer_cnt=1.
6. DEMUX_BROADCAST_EN:
   - Stimulus: in_bcast=1, in_data=16'h1234, ready_c=0 with c FULL.
   - Required response: in_ready=0.
   - Stimulus: after c drains.
   - Required response: the word is accepted, all four out_x=16'h1234 with valid_x=1, xfer_cnt +1.

Source files
------------

// File: rtl/demux_1to4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1to4_reg
//  Purpose  : Registered 1-to-4 demultiplexer with a one-entry valid/ready
//             holding register per output channel and an accepted-word counter.
//             Define DEMUX_BROADCAST_EN to add the in_bcast port (write all four).
//  Revision : 1.0  initial release
// ============================================================================
module demux_1to4_reg #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
`ifdef DEMUX_BROADCAST_EN
   input  logic             in_bcast,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             valid_a,
   output logic             valid_b,
   output logic             valid_c,
   output logic             valid_d,
   input  logic             ready_a,
   input  logic             ready_b,
   input  logic             ready_c,
   input  logic             ready_d,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam int c_NUM_CH = 4;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } chan_state_t;

   logic [c_NUM_CH-1:0] w_ch_ready;
   logic [c_NUM_CH-1:0] w_ch_valid;
   logic [c_NUM_CH-1:0] w_accept;
   logic [c_NUM_CH-1:0] w_dest;
   logic [c_NUM_CH-1:0] w_load;
   logic [WIDTH-1:0]    w_ch_data [c_NUM_CH];
   logic                w_xfer;
   logic [CNT_W-1:0]    r_xfer_cnt;

   assign w_ch_ready = {ready_d, ready_c, ready_b, ready_a};

   // A channel can take a word when empty or when its current word leaves this cycle.
   assign w_accept = ~w_ch_valid | w_ch_ready;

   always_comb begin
      w_dest        = '0;
      w_dest[in_op] = 1'b1;
`ifdef DEMUX_BROADCAST_EN
      if (in_bcast) begin
         w_dest = '1;
      end
`endif
   end

   // Every destination channel must be able to accept; covers unicast and broadcast alike.
   assign in_ready = ((w_accept & w_dest) == w_dest);
   assign w_xfer   = in_valid & in_ready;
   assign w_load   = w_dest & {c_NUM_CH{w_xfer}};

   generate
      for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_chan
         chan_state_t      r_state;
         chan_state_t      w_state_nxt;
         logic [WIDTH-1:0] r_data;

         always_comb begin
            w_state_nxt = r_state;
            case (r_state)
               ST_EMPTY: begin
                  if (w_load[gi]) begin
                     w_state_nxt = ST_FULL;
                  end
               end
               ST_FULL: begin
                  if (!w_load[gi] && w_ch_ready[gi]) begin
                     w_state_nxt = ST_EMPTY;
                  end
               end
               default: w_state_nxt = ST_EMPTY;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_state <= ST_EMPTY;
               r_data  <= '0;
            end else begin
               r_state <= w_state_nxt;
               if (w_load[gi]) begin
                  r_data <= in_data;
               end
            end
         end

         assign w_ch_valid[gi] = (r_state == ST_FULL);
         assign w_ch_data[gi]  = r_data;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_xfer_cnt <= '0;
      end else if (w_xfer) begin
         r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
   end

   assign out_a    = w_ch_data[0];
   assign out_b    = w_ch_data[1];
   assign out_c    = w_ch_data[2];
   assign out_d    = w_ch_data[3];
   assign valid_a  = w_ch_valid[0];
   assign valid_b  = w_ch_valid[1];
   assign valid_c  = w_ch_valid[2];
   assign valid_d  = w_ch_valid[3];
   assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1to4_reg
//  Purpose  : Directed plus randomized bench for demux_1to4_reg against a
//             per-channel valid/data reference model; a CNT_W=4 twin covers wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1to4_reg;

`ifdef DEMUX_BROADCAST_EN
   localparam bit c_BC_EN = 1'b1;
`else
   localparam bit c_BC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        bcast;
   logic [1:0]  in_op;
   logic [15:0] in_data;
   logic [3:0]  rdy;

   logic        in_ready16, in_ready4;
   logic [15:0] o16 [4];
   logic [15:0] o4  [4];
   logic [3:0]  v16, v4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;

   logic        mval [4];
   logic [15:0] mdat [4];
   int unsigned mcnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demux_1to4_reg #(.WIDTH(16), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_op(in_op),
`ifdef DEMUX_BROADCAST_EN
      .in_bcast(bcast),
`endif
      .in_valid(in_valid), .in_ready(in_ready16),
      .out_a(o16[0]), .out_b(o16[1]), .out_c(o16[2]), .out_d(o16[3]),
      .valid_a(v16[0]), .valid_b(v16[1]), .valid_c(v16[2]), .valid_d(v16[3]),
      .ready_a(rdy[0]), .ready_b(rdy[1]), .ready_c(rdy[2]), .ready_d(rdy[3]),
      .xfer_cnt(cnt16)
   );

   demux_1to4_reg #(.WIDTH(16), .CNT_W(4)) u_dut_w4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_op(in_op),
`ifdef DEMUX_BROADCAST_EN
      .in_bcast(bcast),
`endif
      .in_valid(in_valid), .in_ready(in_ready4),
      .out_a(o4[0]), .out_b(o4[1]), .out_c(o4[2]), .out_d(o4[3]),
      .valid_a(v4[0]), .valid_b(v4[1]), .valid_c(v4[2]), .valid_d(v4[3]),
      .ready_a(rdy[0]), .ready_b(rdy[1]), .ready_c(rdy[2]), .ready_d(rdy[3]),
      .xfer_cnt(cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check in_ready mid-cycle, advance model, check outputs.
   task automatic cyc(input logic r, input logic v, input logic [1:0] o,
                      input logic [15:0] d, input logic [3:0] rd, input logic bc);
      logic [3:0] dest;
      logic       exp_rdy;
      logic       xfer;
      rst = r; in_valid = v; in_op = o; in_data = d; rdy = rd; bcast = bc;
      dest = (c_BC_EN && bc) ? 4'hF : (4'b0001 << o);
      exp_rdy = 1'b1;
      for (int i = 0; i < 4; i++)
         if (dest[i] && mval[i] && !rd[i]) exp_rdy = 1'b0;
      @(negedge clk);
      if (!r) begin
         chk("in_ready", {31'b0, in_ready16}, {31'b0, exp_rdy});
         chk("in_ready_w4", {31'b0, in_ready4}, {31'b0, exp_rdy});
      end
      xfer = v && exp_rdy;
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 4; i++) begin mval[i] = 1'b0; mdat[i] = 16'h0; end
         mcnt = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (xfer && dest[i]) begin
               mval[i] = 1'b1;
               mdat[i] = d;
            end else if (mval[i] && rd[i]) begin
               mval[i] = 1'b0;
            end
         end
         if (xfer) mcnt++;
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("out[%0d]", i), {16'b0, o16[i]}, {16'b0, mdat[i]});
         chk($sformatf("valid[%0d]", i), {31'b0, v16[i]}, {31'b0, mval[i]});
         chk($sformatf("out_w4[%0d]", i), {16'b0, o4[i]}, {16'b0, mdat[i]});
      end
      chk("xfer_cnt", {16'b0, cnt16}, mcnt % 65536);
      chk("xfer_cnt_w4", {28'b0, cnt4}, mcnt % 16);
   endtask

   initial begin
      int unsigned saved;
      for (int i = 0; i < 4; i++) begin mval[i] = 1'b0; mdat[i] = 16'h0; end
      mcnt = 0;
      rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_data = 16'h0; rdy = 4'hF; bcast = 1'b0;

      // Reset then unicast to a
      cyc(1'b1, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
      cyc(1'b1, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
      chk("rst_valid", {28'b0, v16}, 32'h0);
      chk("rst_cnt", {16'b0, cnt16}, 32'h0);
      cyc(1'b0, 1'b1, 2'd0, 16'h0007, 4'hF, 1'b0);
      chk("t1_out_a", {16'b0, o16[0]}, 32'h0007);
      chk("t1_valid_a", {31'b0, v16[0]}, 32'h1);
      cyc(1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
      chk("t1_valid_a_drop", {31'b0, v16[0]}, 32'h0);
      chk("t1_cnt", {16'b0, cnt16}, 32'h1);

      // Backpressure on b must not block c
      cyc(1'b0, 1'b1, 2'd1, 16'hFFFD, 4'b1101, 1'b0);
      cyc(1'b0, 1'b1, 2'd1, 16'hF16D, 4'b1101, 1'b0);
      chk("t2_out_b_held", {16'b0, o16[1]}, 32'hFFFD);
      cyc(1'b0, 1'b1, 2'd2, 16'd56, 4'b1101, 1'b0);
      chk("t2_out_c", {16'b0, o16[2]}, 32'd56);
      chk("t2_out_b_still", {16'b0, o16[1]}, 32'hFFFD);
      cyc(1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);

      // Drain and write d in the same cycle
      cyc(1'b0, 1'b1, 2'd3, 16'hF0FD, 4'b0111, 1'b0);
      saved = mcnt;
      cyc(1'b0, 1'b1, 2'd3, 16'd45, 4'hF, 1'b0);
      chk("t3_out_d", {16'b0, o16[3]}, 32'd45);
      chk("t3_valid_d", {31'b0, v16[3]}, 32'h1);
      chk("t3_cnt", {16'b0, cnt16}, saved + 1);

      // Round-robin stream at full rate
      cyc(1'b0, 1'b1, 2'd0, 16'd8, 4'hF, 1'b0);
      cyc(1'b0, 1'b1, 2'd1, 16'd4, 4'hF, 1'b0);
      cyc(1'b0, 1'b1, 2'd2, 16'd45, 4'hF, 1'b0);
      cyc(1'b0, 1'b1, 2'd3, 16'hF0FD, 4'hF, 1'b0);
      cyc(1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b0);
      chk("t4_all_drained", {28'b0, v16}, 32'h0);

      // Reset mid-handshake, then counter wrap on the CNT_W=4 twin
      cyc(1'b0, 1'b1, 2'd0, 16'hAAAA, 4'b1110, 1'b0);
      chk("t5_valid_a_set", {31'b0, v16[0]}, 32'h1);
      cyc(1'b1, 1'b0, 2'd0, 16'h0000, 4'b1110, 1'b0);
      chk("t5_out_a_rst", {16'b0, o16[0]}, 32'h0);
      for (int k = 0; k < 17; k++)
         cyc(1'b0, 1'b1, 2'(k), 16'(k + 1), 4'hF, 1'b0);
      chk("t5_wrap_w4", {28'b0, cnt4}, 32'h1);
      chk("t5_cnt16", {16'b0, cnt16}, 32'd17);

`ifdef DEMUX_BROADCAST_EN
      // Broadcast blocked by a stalled full channel, then accepted once it drains
      cyc(1'b0, 1'b1, 2'd2, 16'hBEEF, 4'b1011, 1'b0);
      cyc(1'b0, 1'b1, 2'd0, 16'h1234, 4'b1011, 1'b1);
      chk("t6_c_held", {16'b0, o16[2]}, 32'hBEEF);
      saved = mcnt;
      cyc(1'b0, 1'b1, 2'd1, 16'h1234, 4'hF, 1'b1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t6_out[%0d]", i), {16'b0, o16[i]}, 32'h1234);
      chk("t6_valids", {28'b0, v16}, 32'hF);
      chk("t6_cnt", {16'b0, cnt16}, saved + 1);
`endif

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         cyc(($urandom_range(0, 63) == 0),
             1'($urandom),
             2'($urandom),
             16'($urandom),
             4'($urandom) | 4'($urandom),
             ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
